regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback stage
// and a multi-cycle unit, with WAW ordering and a starvation limit for the MDU.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        StallW,
  output logic        RegWrite,
  output logic [4:0]  Rd,
  output logic [31:0] Result
);

  localparam int unsigned CntW =
      ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

  typedef enum logic [0:0] {StNormal, StForce} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d, wait_inc;
  logic              preq, mreq, pipe_gnt, mdu_gnt;
  logic              reg_write_q, reg_write_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       result_q, result_d;

  always_comb begin
    preq       = RegWriteW && (RdW != 5'd0);
    mreq       = mdu_valid && (mdu_rd != 5'd0);
    wait_inc   = (wait_cnt_q == CntW'(STARVE_LIMIT)) ? wait_cnt_q : wait_cnt_q + CntW'(1);
    pipe_gnt   = 1'b0;
    mdu_gnt    = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      StNormal: begin
        if (preq && mreq) begin
          // Same destination: the MDU instruction is older, so it must land first.
          if (RdW == mdu_rd) begin
            mdu_gnt = 1'b1;
          end else begin
            pipe_gnt   = 1'b1;
            wait_cnt_d = wait_inc;
            if (wait_inc == CntW'(STARVE_LIMIT)) state_d = StForce;
          end
        end else begin
          pipe_gnt = preq;
          mdu_gnt  = mreq;
        end
      end
      StForce: begin
        // A vanished MDU request simply falls back to NORMAL without a write.
        mdu_gnt    = mreq;
        state_d    = StNormal;
        wait_cnt_d = '0;
      end
      default: state_d = StNormal;
    endcase

    if (mdu_gnt) wait_cnt_d = '0;

    mdu_ready = mdu_gnt || (mdu_valid && (mdu_rd == 5'd0));
    StallW    = preq && !pipe_gnt;

    reg_write_d = pipe_gnt || mdu_gnt;
    rd_d        = rd_q;
    result_d    = result_q;
    if (mdu_gnt) begin
      rd_d     = mdu_rd;
      result_d = mdu_data;
    end else if (pipe_gnt) begin
      rd_d     = RdW;
      result_d = ResultW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StNormal;
      wait_cnt_q  <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      result_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
    end
  end

  assign RegWrite = reg_write_q;
  assign Rd       = rd_q;
  assign Result   = result_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a request-level arbitration model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_regfile_write_arbiter;

  localparam int unsigned Limit = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteW = 1'b0;
  logic [4:0]  RdW = 5'd0;
  logic [31:0] ResultW = 32'd0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_rd = 5'd0;
  logic [31:0] mdu_data = 32'd0;
  logic        mdu_ready, StallW, RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Result;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk       (clk),
    .rst       (rst),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .ResultW   (ResultW),
    .mdu_valid (mdu_valid),
    .mdu_rd    (mdu_rd),
    .mdu_data  (mdu_data),
    .mdu_ready (mdu_ready),
    .StallW    (StallW),
    .RegWrite  (RegWrite),
    .Rd        (Rd),
    .Result    (Result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a forced-turn flag, count of lost MDU contests, and the expected write port.
  bit          m_force = 1'b0;
  int          m_starved = 0;
  bit          m_we = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_res = 32'd0;

  function automatic void arb(output bit pipe_wins, output bit mdu_wins, output bit p, output bit m);
    p = RegWriteW && (RdW != 0);
    m = mdu_valid && (mdu_rd != 0);
    pipe_wins = 1'b0;
    mdu_wins  = 1'b0;
    if (m_force)          mdu_wins = m;
    else if (p && m)      begin if (RdW == mdu_rd) mdu_wins = 1'b1; else pipe_wins = 1'b1; end
    else                  begin pipe_wins = p; mdu_wins = m; end
  endfunction

  always @(posedge clk or posedge rst) begin
    bit pw, mw, p, m;
    if (rst) begin
      m_force = 1'b0; m_starved = 0; m_we = 1'b0; m_rd = 5'd0; m_res = 32'd0;
    end else begin
      arb(pw, mw, p, m);
      m_we = pw || mw;
      if (mw) begin
        m_rd = mdu_rd; m_res = mdu_data; m_starved = 0; m_force = 1'b0;
      end else if (m_force) begin
        m_force = 1'b0; m_starved = 0;
      end else begin
        if (pw) begin m_rd = RdW; m_res = ResultW; end
        if (pw && m) begin
          m_starved++;
          if (m_starved == Limit) m_force = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit pw, mw, p, m;
    arb(pw, mw, p, m);
    chk("model StallW", {31'd0, StallW}, {31'd0, p && !pw});
    chk("model mdu_ready", {31'd0, mdu_ready},
        {31'd0, mw || (mdu_valid && mdu_rd == 0)});
    chk("model RegWrite", {31'd0, RegWrite}, {31'd0, m_we});
    chk("model Rd", {27'd0, Rd}, {27'd0, m_rd});
    chk("model Result", Result, m_res);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) step();
    chk("reset RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("reset Rd", {27'd0, Rd}, 32'd0);
    chk("reset Result", Result, 32'd0);
    rst = 1'b0;

    // Pipeline-only write, granted in the first cycle out of reset.
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hA5A5_A5A5;
    #1 chk("pipe StallW", {31'd0, StallW}, 32'd0);
    step();
    chk("pipe RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("pipe Rd", {27'd0, Rd}, 32'd5);
    chk("pipe Result", Result, 32'hA5A5_A5A5);
    idle();

    // MDU-only write.
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h1234_5678;
    #1 chk("mdu ready", {31'd0, mdu_ready}, 32'd1);
    step();
    chk("mdu RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("mdu Rd", {27'd0, Rd}, 32'd7);
    chk("mdu Result", Result, 32'h1234_5678);
    idle();
    step();
    chk("idle RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("idle Rd held", {27'd0, Rd}, 32'd7);

    // Starvation: pipeline wins Limit cycles, then the MDU is forced through.
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h3333_3333;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h9999_9999;
    for (int i = 0; i < Limit; i++) begin
      #1 chk("starve StallW", {31'd0, StallW}, 32'd0);
      chk("starve ready", {31'd0, mdu_ready}, 32'd0);
      step();
      chk("starve Rd", {27'd0, Rd}, 32'd3);
    end
    #1 chk("force StallW", {31'd0, StallW}, 32'd1);
    chk("force ready", {31'd0, mdu_ready}, 32'd1);
    step();
    chk("force Rd", {27'd0, Rd}, 32'd9);
    chk("force Result", Result, 32'h9999_9999);
    mdu_valid = 1'b0;
    #1 chk("after force StallW", {31'd0, StallW}, 32'd0);
    step();
    chk("after force Rd", {27'd0, Rd}, 32'd3);
    idle();

    // WAW on the same destination: MDU first, then the held pipeline write.
    RegWriteW = 1'b1; RdW = 5'd10; ResultW = 32'h1010_1010;
    mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'hAAAA_0000;
    #1 chk("waw StallW", {31'd0, StallW}, 32'd1);
    chk("waw ready", {31'd0, mdu_ready}, 32'd1);
    step();
    chk("waw mdu Result", Result, 32'hAAAA_0000);
    mdu_valid = 1'b0;
    step();
    chk("waw pipe RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("waw pipe Rd", {27'd0, Rd}, 32'd10);
    chk("waw pipe Result", Result, 32'h1010_1010);
    idle();

    // Writes to x0 from both sides.
    RegWriteW = 1'b1; RdW = 5'd0; mdu_valid = 1'b1; mdu_rd = 5'd0;
    #1 chk("x0 ready", {31'd0, mdu_ready}, 32'd1);
    chk("x0 StallW", {31'd0, StallW}, 32'd0);
    step();
    chk("x0 RegWrite", {31'd0, RegWrite}, 32'd0);
    idle();

    // Two lost contests, then an MDU grant must clear the starvation count.
    RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'h4444_4444;
    mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_data = 32'h6666_6666;
    repeat (2) step();
    RegWriteW = 1'b0;
    step();
    chk("clear Rd", {27'd0, Rd}, 32'd6);
    RegWriteW = 1'b1; mdu_rd = 5'd12; mdu_data = 32'hCCCC_CCCC;
    for (int i = 0; i < Limit; i++) begin
      #1 chk("recount ready", {31'd0, mdu_ready}, 32'd0);
      step();
    end
    // Now in the forced cycle: an async reset must abort the MDU write.
    #1 chk("pre-rst ready", {31'd0, mdu_ready}, 32'd1);
    rst = 1'b1;
    #1 chk("async RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("async Rd", {27'd0, Rd}, 32'd0);
    chk("async Result", Result, 32'd0);
    chk("rst ready", {31'd0, mdu_ready}, 32'd0);
    step();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post-rst RegWrite", {31'd0, RegWrite}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
